avalon_uart_ext: RTL

Parametrised, self-contained Avalon-MM UART with configurable FIFO depth, runtime frame format (5–8 data bits, optional parity, 1/2 stop bits), per-entry RX error flags, sticky error status and a masked combined interrupt. It is the next-generation drop-in peripheral for SoC designs on the Avalon bus. It contains its own TX/RX serialisers and FIFOs, so it has no sub-module dependencies.

---
 rtl/avalon_uart_ext.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/avalon_uart_ext.sv
`timescale 1ns/1ps
// Avalon-MM UART with TX/RX FIFOs, runtime frame format, per-entry RX error
// flags, sticky write-1-to-clear status and a masked, registered interrupt.
//
// state    | meaning (shared by the TX and RX FSMs)
// S_IDLE   | line idle; TX waits for an entry, RX waits for a falling edge
// S_START  | start bit
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit, only entered when parity is enabled
// S_STOP   | stop bit(s); RX leaves at the sample point of the first one
module avalon_uart_ext #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  avn_address,
    input  logic        avn_read,
    input  logic        avn_write,
    input  logic [31:0] avn_writedata,
    output logic [31:0] avn_readdata,
    output logic        avn_waitrequest,
    output logic        irq,
    output logic        uart_txd,
    input  logic        uart_rxd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic          txen, nstop, rxen;
    logic [CW-1:0] txcnt, rxcnt;
    logic [2:0]    ie, ip;
    logic [15:0]   div;
    logic [3:0]    frame, status, status_set, status_clr;
    logic [3:0]    idx;
    logic [31:0]   rd_mux;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [9:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, tx_ovf, rx_push, rx_pop, rx_ovr;

    state_t        tx_state, tx_next, rx_state, rx_next;
    logic [15:0]   tx_tmr, tx_div, rx_tmr, rx_div, rx_samp_pt;
    logic [2:0]    tx_bit, tx_len, rx_bit, rx_len;
    logic [7:0]    tx_shift, len_mask, rx_data;
    logic          tx_par_en, tx_par_bit, tx_nstop, tx_stop_idx, tx_tc;
    logic          rx_par_en, rx_par_odd, rx_perr, rx_tc, rx_samp, rx_fall;
    logic          rxd_s1, rxd_s2, rxd_s3, rx_push_q;
    logic [9:0]    rx_push_data;
    logic          unused_bits;

    assign unused_bits     = ^{avn_address[1:0], avn_writedata[31:16+CW]};
    assign avn_waitrequest = 1'b0;
    assign idx      = avn_address[5:2];
    assign tx_full  = (tx_count == DEPTH_C);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == DEPTH_C);
    assign rx_empty = (rx_count == '0);
    assign tx_push  = avn_write && idx == 4'd0 && !tx_full;
    assign tx_ovf   = avn_write && idx == 4'd0 && tx_full;
    assign tx_pop   = tx_state == S_IDLE && txen && !tx_empty;
    assign rx_pop   = avn_read && idx == 4'd1 && !rx_empty;
    // A full RX FIFO still accepts a push when the head leaves on the same edge.
    assign rx_push  = rx_push_q && (!rx_full || rx_pop);
    assign rx_ovr   = rx_push_q && rx_full && !rx_pop;
    assign ip       = {|status, rx_count > rxcnt, tx_count < txcnt};
    assign len_mask = 8'hFF >> (2'd3 - frame[3:2]);
    assign status_set = {tx_ovf, rx_push_q & rx_push_data[9], rx_push_q & rx_push_data[8], rx_ovr};
    assign status_clr = (avn_write && idx == 4'd8) ? avn_writedata[3:0] : 4'd0;

    always_comb begin
        rd_mux = '0;
        case (idx)
            4'd0: rd_mux[31] = tx_full;
            4'd1: rd_mux = rx_empty ? 32'h8000_0000 : {22'b0, rx_mem[rx_rp]};
            4'd2: begin rd_mux[0] = txen; rd_mux[1] = nstop; rd_mux[16 +: CW] = txcnt; end
            4'd3: begin rd_mux[0] = rxen; rd_mux[16 +: CW] = rxcnt; end
            4'd4: rd_mux[2:0] = ie;
            4'd5: rd_mux[2:0] = ip;
            4'd6: rd_mux[15:0] = div;
            4'd7: rd_mux[3:0] = frame;
            4'd8: rd_mux[3:0] = status;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txen <= 1'b0; nstop <= 1'b0; rxen <= 1'b0;
            txcnt <= '0; rxcnt <= '0; ie <= '0; frame <= '0; status <= '0;
            div <= DIV_RESET; irq <= 1'b0; avn_readdata <= '0;
        end else begin
            if (avn_write) begin
                case (idx)
                    4'd2: begin txen <= avn_writedata[0]; nstop <= avn_writedata[1]; txcnt <= avn_writedata[16 +: CW]; end
                    4'd3: begin rxen <= avn_writedata[0]; rxcnt <= avn_writedata[16 +: CW]; end
                    4'd4: ie <= avn_writedata[2:0];
                    4'd6: div <= avn_writedata[15:0];
                    4'd7: frame <= avn_writedata[3:0];
                    default: ;
                endcase
            end
            status <= (status & ~status_clr) | status_set;
            irq <= |(ip & ie);
            if (avn_read) avn_readdata <= rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= avn_writedata[7:0];
        if (rx_push) rx_mem[rx_wp] <= rx_push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
            rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    assign tx_tc = (tx_tmr == 16'd0);

    always_comb begin
        tx_next  = tx_state;
        uart_txd = 1'b1;
        case (tx_state)
            S_IDLE:   if (tx_pop) tx_next = S_START;
            S_START:  begin uart_txd = 1'b0; if (tx_tc) tx_next = S_DATA; end
            S_DATA:   begin
                uart_txd = tx_shift[0];
                if (tx_tc && tx_bit == tx_len) tx_next = tx_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin uart_txd = tx_par_bit; if (tx_tc) tx_next = S_STOP; end
            S_STOP:   if (tx_tc && tx_stop_idx == tx_nstop) tx_next = S_IDLE;
            default:  tx_next = S_IDLE;
        endcase
    end

    // Frame format, stop count and divisor are frozen at pop for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE; tx_tmr <= '0; tx_div <= '0; tx_bit <= '0; tx_len <= '0;
            tx_shift <= '0; tx_par_en <= 1'b0; tx_par_bit <= 1'b0; tx_nstop <= 1'b0; tx_stop_idx <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_shift    <= tx_mem[tx_rp];
                tx_len      <= {1'b0, frame[3:2]} + 3'd4;
                tx_par_en   <= frame[1] ^ frame[0];
                tx_par_bit  <= (^(tx_mem[tx_rp] & len_mask)) ^ frame[1];
                tx_nstop    <= nstop;
                tx_div      <= div;
                tx_tmr      <= div;
                tx_bit      <= '0;
                tx_stop_idx <= 1'b0;
            end else if (tx_state != S_IDLE) begin
                if (tx_tc) begin
                    tx_tmr <= tx_div;
                    if (tx_state == S_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                    if (tx_state == S_STOP) tx_stop_idx <= 1'b1;
                end else begin
                    tx_tmr <= tx_tmr - 16'd1;
                end
            end
        end
    end

    assign rx_fall = rxd_s3 & ~rxd_s2;
    assign rx_tc   = (rx_tmr == 16'd0);
    assign rx_samp = (rx_tmr == rx_samp_pt);

    always_comb begin
        rx_next = rx_state;
        if (!rxen) begin
            rx_next = S_IDLE;
        end else begin
            case (rx_state)
                S_IDLE:   if (rx_fall) rx_next = S_START;
                S_START:  if (rx_samp && rxd_s2) rx_next = S_IDLE;
                          else if (rx_tc) rx_next = S_DATA;
                S_DATA:   if (rx_tc && rx_bit == rx_len) rx_next = rx_par_en ? S_PARITY : S_STOP;
                S_PARITY: if (rx_tc) rx_next = S_STOP;
                S_STOP:   if (rx_samp) rx_next = S_IDLE;
                default:  rx_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_s1 <= 1'b1; rxd_s2 <= 1'b1; rxd_s3 <= 1'b1;
            rx_state <= S_IDLE; rx_tmr <= '0; rx_div <= '0; rx_samp_pt <= '0;
            rx_bit <= '0; rx_len <= '0; rx_data <= '0; rx_par_en <= 1'b0; rx_par_odd <= 1'b0;
            rx_perr <= 1'b0; rx_push_q <= 1'b0; rx_push_data <= '0;
        end else begin
            rxd_s1    <= uart_rxd;
            rxd_s2    <= rxd_s1;
            rxd_s3    <= rxd_s2;
            rx_state  <= rx_next;
            rx_push_q <= 1'b0;
            if (rx_state == S_IDLE) begin
                if (rx_next == S_START) begin
                    rx_tmr     <= div;
                    rx_div     <= div;
                    rx_samp_pt <= div - (div >> 1);
                    rx_len     <= {1'b0, frame[3:2]} + 3'd4;
                    rx_par_en  <= frame[1] ^ frame[0];
                    rx_par_odd <= frame[1];
                    rx_data    <= '0;
                    rx_bit     <= '0;
                    rx_perr    <= 1'b0;
                end
            end else if (rxen) begin
                rx_tmr <= rx_tc ? rx_div : rx_tmr - 16'd1;
                if (rx_samp) begin
                    case (rx_state)
                        S_DATA:   rx_data[rx_bit] <= rxd_s2;
                        S_PARITY: rx_perr <= rxd_s2 ^ (^rx_data) ^ rx_par_odd;
                        S_STOP:   begin
                            rx_push_q    <= 1'b1;
                            rx_push_data <= {rx_perr, ~rxd_s2, rx_data};
                        end
                        default: ;
                    endcase
                end
                if (rx_tc && rx_state == S_DATA) rx_bit <= rx_bit + 3'd1;
            end
        end
    end
endmodule
